multi_cycle_ctrl: RTL

- Multi-cycle control unit for the 32-bit MIPS-subset datapath: one FSM sequences fetch, decode, execute, memory and writeback over several clocks.
- Reuses a single ALU and a single memory port across steps.
- Sits between the instruction register opcode and the datapath muxes and enables: PC, IR, register file, ALU, and MIO bus.
- Stalls on the MIO_ready memory handshake.

---
 rtl/multi_cycle_ctrl_if.sv | 42 ++++
 rtl/multi_cycle_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl_if.sv
// Control bundle between multi_cycle_ctrl (master) and the MIPS datapath (slave).
// Carries the decode inputs, the memory handshake and every datapath enable/select.
interface multi_cycle_ctrl_if #(
  parameter int unsigned OP_W = 6,
  parameter int unsigned ST_W = 4
);
  logic [OP_W-1:0] opcode;
  logic            zero;
  logic            MIO_ready;
  logic            INT;

  logic            PCWrite;
  logic            PCWriteCond;
  logic            IorD;
  logic            MemRead;
  logic            MemWrite;
  logic            CPU_MIO;
  logic            IRWrite;
  logic            RegDst;
  logic            MemtoReg;
  logic            RegWrite;
  logic            ALUSrcA;
  logic [1:0]      ALUSrcB;
  logic [1:0]      ALUOp;
  logic [1:0]      PCSource;
  logic [ST_W-1:0] state;
  logic            illegal;

  modport master (
    input  opcode, zero, MIO_ready, INT,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, CPU_MIO, IRWrite,
           RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           state, illegal
  );

  modport slave (
    output opcode, zero, MIO_ready, INT,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, CPU_MIO, IRWrite,
           RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           state, illegal
  );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM: sequences fetch/decode/execute/memory/writeback.
// Optional interrupt entry at instruction boundaries is enabled by defining MCCTRL_INT_EN.
module multi_cycle_ctrl #(
  parameter int unsigned OP_W    = 6,
  parameter int unsigned ST_W    = 4,
  parameter logic [31:0] INT_VEC = 32'h0000_0004
) (
  input logic                clk,
  input logic                rst,
  multi_cycle_ctrl_if.master bus
);

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(6'b001100);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b001101);
  localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(6'b001010);

  typedef enum logic [ST_W-1:0] {
    S_IF   = ST_W'(0),
    S_ID   = ST_W'(1),
    S_MADR = ST_W'(2),
    S_MRD  = ST_W'(3),
    S_LWWB = ST_W'(4),
    S_MWR  = ST_W'(5),
    S_EXR  = ST_W'(6),
    S_RWB  = ST_W'(7),
    S_BEQ  = ST_W'(8),
    S_JMP  = ST_W'(9),
    S_EXI  = ST_W'(10),
    S_IWB  = ST_W'(11),
    S_INTR = ST_W'(12)
  } state_e;

  state_e state_q;
  state_e state_d;
  logic   instr_done_c;
  logic   illegal_c;

  // INT_VEC is applied by the datapath when PCSource selects it; zero gates PCWriteCond there.
  logic unused_ok;
`ifdef MCCTRL_INT_EN
  assign unused_ok = ^{INT_VEC, bus.zero};
`else
  assign unused_ok = ^{INT_VEC, bus.zero, bus.INT};
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IF;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; instr_done_c marks the cycle that closes an instruction.
  always_comb begin
    state_d      = state_q;
    instr_done_c = 1'b0;
    illegal_c    = 1'b0;
    case (state_q)
      S_IF: begin
        if (bus.MIO_ready) state_d = S_ID;
      end
      S_ID: begin
        case (bus.opcode)
          OP_RTYPE:                          state_d = S_EXR;
          OP_LW, OP_SW:                      state_d = S_MADR;
          OP_BEQ:                            state_d = S_BEQ;
          OP_J:                              state_d = S_JMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_EXI;
          default: begin
            state_d   = S_IF;
            illegal_c = 1'b1;
          end
        endcase
      end
      S_MADR: begin
        if (bus.opcode == OP_LW)      state_d = S_MRD;
        else if (bus.opcode == OP_SW) state_d = S_MWR;
        else                          state_d = S_IF;
      end
      S_MRD: begin
        if (bus.MIO_ready) state_d = S_LWWB;
      end
      S_MWR: begin
        if (bus.MIO_ready) instr_done_c = 1'b1;
      end
      S_LWWB, S_RWB, S_IWB, S_BEQ, S_JMP: instr_done_c = 1'b1;
      S_EXR:   state_d = S_RWB;
      S_EXI:   state_d = S_IWB;
      S_INTR:  state_d = S_IF;
      default: state_d = S_IF;
    endcase

`ifdef MCCTRL_INT_EN
    if (illegal_c || (instr_done_c && bus.INT)) state_d = S_INTR;
    else if (instr_done_c)                      state_d = S_IF;
`else
    if (instr_done_c || illegal_c) state_d = S_IF;
`endif
  end

  // Datapath controls decoded from the current state; all forced low while in reset.
  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.RegDst      = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.ALUOp       = 2'b00;
    bus.PCSource    = 2'b00;
    bus.illegal     = 1'b0;
    bus.state       = '0;
    if (rst) begin
      bus.state = ST_W'(state_q);
      case (state_q)
        S_IF: begin
          bus.MemRead = 1'b1;
          bus.ALUSrcB = 2'b01;
          bus.IRWrite = bus.MIO_ready;
          bus.PCWrite = bus.MIO_ready;
        end
        S_ID: begin
          bus.ALUSrcB = 2'b11;
          bus.illegal = illegal_c;
        end
        S_MADR: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = 2'b10;
        end
        S_MRD: begin
          bus.MemRead = 1'b1;
          bus.IorD    = 1'b1;
        end
        S_LWWB: begin
          bus.RegWrite = 1'b1;
          bus.MemtoReg = 1'b1;
        end
        S_MWR: begin
          bus.MemWrite = 1'b1;
          bus.IorD     = 1'b1;
        end
        S_EXR: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUOp   = 2'b10;
        end
        S_RWB: begin
          bus.RegWrite = 1'b1;
          bus.RegDst   = 1'b1;
        end
        S_EXI: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = 2'b10;
          bus.ALUOp   = 2'b11;
        end
        S_IWB: begin
          bus.RegWrite = 1'b1;
        end
        S_BEQ: begin
          bus.ALUSrcA     = 1'b1;
          bus.ALUOp       = 2'b01;
          bus.PCWriteCond = 1'b1;
          bus.PCSource    = 2'b01;
        end
        S_JMP: begin
          bus.PCWrite  = 1'b1;
          bus.PCSource = 2'b10;
        end
`ifdef MCCTRL_INT_EN
        S_INTR: begin
          bus.PCWrite  = 1'b1;
          bus.PCSource = 2'b11;
        end
`endif
        default: begin
          bus.PCWrite = 1'b0;
        end
      endcase
    end
    bus.CPU_MIO = bus.MemRead | bus.MemWrite;
  end

endmodule
